// File: rtl/tspp_prefetch_buffer_if.sv
// Bus and fetch-stage signal bundle for tspp_prefetch_buffer.
// master = prefetch buffer side, slave = bus/fetch environment side.
interface tspp_prefetch_buffer_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          pop;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic [CW-1:0] count;
  logic [31:0]   bus_addr;
  logic          bus_ren;
  logic [31:0]   bus_rdata;
  logic          bus_busy;

  modport master (
    input  redirect, redirect_pc, pop, bus_rdata, bus_busy,
    output instr_valid, instr, instr_pc, count, bus_addr, bus_ren
  );

  modport slave (
    output redirect, redirect_pc, pop, bus_rdata, bus_busy,
    input  instr_valid, instr, instr_pc, count, bus_addr, bus_ren
  );
endinterface

// File: rtl/tspp_prefetch_buffer.sv
// Instruction prefetch queue: sequential word reads ahead of fetch, flush on redirect.
// Optional PREFETCH_BYPASS_EN exposes a completing read directly when the queue is empty.
module tspp_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h200
) (
  input logic                    clk,
  input logic                    rst,
  tspp_prefetch_buffer_if.master pf
);
  localparam int unsigned   AW     = $clog2(DEPTH);
  localparam int unsigned   CW     = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

  state_e        state_q, state_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic done, push, q_push, q_pop, head_valid;

  assign done       = (state_q == StReq) && !pf.bus_busy;
  assign push       = done && !pf.redirect;
  assign head_valid = (count_q != '0);
  assign q_pop      = pf.pop && head_valid;

`ifdef PREFETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = push && !head_valid;
  // A word consumed straight off the bus never enters the queue.
  assign q_push     = push && !(bypass_hit && pf.pop);
`else
  assign q_push     = push;
`endif

  always_comb begin
    count_d = count_q;
    if (pf.redirect) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(q_push) - CW'(q_pop);
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    fetch_pc_d = fetch_pc_q;
    if (pf.redirect) begin
      fetch_pc_d = {pf.redirect_pc[31:2], 2'b00};
    end
    unique case (state_q)
      StIdle: begin
        if (!pf.redirect && (count_d < DepthC)) begin
          state_d    = StReq;
          req_addr_d = fetch_pc_q;
        end
      end
      StReq: begin
        if (pf.redirect) begin
          // The bus read cannot be aborted; wait it out and drop its data.
          state_d = pf.bus_busy ? StDiscard : StIdle;
        end else if (!pf.bus_busy) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (count_d < DepthC) begin
            req_addr_d = fetch_pc_q + 32'd4;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDiscard: begin
        if (!pf.bus_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      req_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      if (pf.redirect) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (q_push) begin
          wptr_q <= wptr_q + 1'b1;
        end
        if (q_pop) begin
          rptr_q <= rptr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && q_push) begin
      pc_mem[wptr_q]    <= req_addr_q;
      instr_mem[wptr_q] <= pf.bus_rdata;
    end
  end

  always_comb begin
    pf.instr_valid = head_valid;
    pf.instr       = instr_mem[rptr_q];
    pf.instr_pc    = pc_mem[rptr_q];
`ifdef PREFETCH_BYPASS_EN
    if (bypass_hit) begin
      pf.instr_valid = 1'b1;
      pf.instr       = pf.bus_rdata;
      pf.instr_pc    = req_addr_q;
    end
`endif
  end

  assign pf.count    = count_q;
  assign pf.bus_addr = req_addr_q;
  assign pf.bus_ren  = (state_q != StIdle);
endmodule
